sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO. It is the synchronous successor to the team's dual-clock FIFO and keeps the same push/pop/full/empty handshake names. It adds depth and width parameters, programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It buffers streams between blocks that share one clock domain and gives testbench drivers and monitors a level-aware endpoint.

Parameters:
DWIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AFULL_TH, DEPTH-2, afull asserted when count >= AFULL_TH
AEMPTY_TH, 2, aempty asserted when count <= AEMPTY_TH

Ports:
clk  input  1  single clock; all logic on posedge
reset  input  1  synchronous, active-high reset
push  input  1  write request
wdata  input  DWIDTH  write data
full  output  1  count == DEPTH
afull  output  1  count >= AFULL_TH
pop  input  1  read request
rdata  output  DWIDTH  read data
rvalid  output  1  rdata holds a popped word this cycle (standard mode)
empty  output  1  count == 0
aempty  output  1  count <= AEMPTY_TH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: push seen while full
underflow  output  1  sticky: pop seen while empty
err_clr  input  1  clears overflow/underflow

Behaviour:
- Reset is sampled on posedge clk only. It sets wptr=0, rptr=0, count=0, full=0, afull=0, empty=1, aempty=1, rvalid=0, rdata=0, overflow=0, underflow=0. Storage contents are not cleared.
- Reset overrides every other input in the same cycle, including push, pop and err_clr. Reset mid-stream discards all entries.
- Pointers are $clog2(DEPTH)+1 bits; the extra MSB is the wrap bit. full = (MSBs differ and low bits are equal); empty = (pointers equal). count = wptr - rptr, modulo 2^(AW+1).
- Write acceptance: wr_en = push & ~full. It stores wdata at wptr[AW-1:0] and increments wptr.
- Read acceptance: rd_en = pop & ~empty. It increments rptr.
- Flags are evaluated before the current cycle's update. Consequences:
  - push while full is rejected even if pop is also accepted that cycle.
  - pop while empty is rejected even if push is also accepted that cycle.
- Simultaneous accepted push and pop leave count unchanged.
- All flags and count are registered and reflect state after the edge. There is no combinational path from push/pop to any flag.
- Standard mode read latency is 1. On the edge where rd_en is true, rdata <= mem[rptr]. On the next cycle rvalid=1. Otherwise rvalid=0 and rdata holds its last value.
- Error flags:
  - overflow <= 1 when push & full.
  - underflow <= 1 when pop & empty.
  - err_clr clears both on the next edge. Setting wins over err_clr in the same cycle.
- Rejected operations do not modify storage, pointers or count.
- Elaboration checks: DEPTH must be a power of two, 0 < AEMPTY_TH < AFULL_TH < DEPTH. Any violation raises $fatal.
- Internal state is one 2-state write/read status per side, with no separate FSM. Sequencing comes from pointer compare plus the rvalid pipeline register.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined: first-word fall-through mode.
  - rdata always presents mem[rptr] when empty=0; it is registered from the next-head lookahead.
  - rvalid = ~empty.
  - pop consumes the presented word; read latency is 0.
  - A word pushed into an empty FIFO appears on rdata one cycle after the push edge, the same cycle empty deasserts.
- Undefined: standard 1-cycle-latency mode as described in Behaviour.
- Flags, count, thresholds and error logic are identical in both modes.

Decomposition:
- Package sync_fifo_pkg holds:
  - function ptr_w(depth) returning $clog2(depth)+1
  - typedef fifo_err_t, a struct {overflow, underflow}
  - localparam defaults for thresholds
- Natural sub-module: sync_fifo_ram, a DEPTH x DWIDTH storage array with one registered write port and an async read port. Pointer, flag and read-pipeline logic stays in sync_fifo_ctrl.

Test Plan:
- DEPTH=8, DWIDTH=8, standard mode. Reset, then push 0x01..0x08 on consecutive cycles:
  - full=1 after the 8th edge, count=8, afull=1 from count=6.
  - A 9th push sets overflow=1; count stays 8.
- From full, pop 8 times: rdata sequence is 0x01..0x08, each with rvalid=1 one cycle after its pop. empty=1 after the last pop; aempty=1 from count=2.
- Empty FIFO, pop=1 with push=1 (0xAA) in the same cycle:
  - underflow=1, count=1, rvalid=0.
  - The next pop returns 0xAA.
- Full FIFO, push (0x55) and pop together:
  - pop is accepted, push is rejected, overflow=1, count=7.
- Wrap-around: push and pop continuously for 40 cycles at count=4. Data order is preserved across pointer wrap and count stays 4.
- Assert reset mid-stream at count=5: the next cycle shows empty=1, count=0, rvalid=0. Errors are set and then err_clr=1 clears both. With SYNC_FIFO_FWFT_EN, a push of 0x3C into an empty FIFO shows rdata=0x3C, rvalid=1 one cycle later.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types, defaults and helpers for the single-clock FIFO.
package sync_fifo_pkg;

  localparam int unsigned AEMPTY_TH_DEF    = 2;
  localparam int unsigned AFULL_MARGIN_DEF = 2;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Push/pop handshake bundle for sync_fifo_ctrl; master drives requests, slave is the FIFO.
interface sync_fifo_ctrl_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned PW = ptr_w(DEPTH);

  logic              push;
  logic [DWIDTH-1:0] wdata;
  logic              full;
  logic              afull;
  logic              pop;
  logic [DWIDTH-1:0] rdata;
  logic              rvalid;
  logic              empty;
  logic              aempty;
  logic [PW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  modport master (
    output push, wdata, pop, err_clr,
    input  full, afull, rdata, rvalid, empty, aempty, count, overflow, underflow
  );

  modport slave (
    input  push, wdata, pop, err_clr,
    output full, afull, rdata, rvalid, empty, aempty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// DEPTH x DWIDTH storage: registered write port, asynchronous read port, contents never reset.
module sync_fifo_ram #(
  parameter  int unsigned DWIDTH = 8,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, registered flags, sticky errors, read pipeline.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is 1-cycle read latency.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = DEPTH - AFULL_MARGIN_DEF,
  parameter int unsigned AEMPTY_TH = AEMPTY_TH_DEF
) (
  input logic             clk,
  input logic             reset,
  sync_fifo_ctrl_if.slave bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4) || (AEMPTY_TH == 0) ||
      (AEMPTY_TH >= AFULL_TH) || (AFULL_TH >= DEPTH)) begin : g_bad_cfg
    $fatal(1, "sync_fifo_ctrl: illegal DEPTH/threshold configuration");
  end

  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              afull_q, afull_d, aempty_q, aempty_d;
  logic              wr_en, rd_en;
  fifo_err_t         err_q, err_d;
  logic [DWIDTH-1:0] rdata_q, ram_rdata;
  logic [AW-1:0]     raddr;

  always_comb begin
    // Acceptance uses the flags registered before this edge.
    wr_en    = bus.push & ~full_q;
    rd_en    = bus.pop & ~empty_q;
    wptr_d   = wptr_q + {{AW{1'b0}}, wr_en};
    rptr_d   = rptr_q + {{AW{1'b0}}, rd_en};
    count_d  = wptr_d - rptr_d;
    full_d   = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    empty_d  = (wptr_d == rptr_d);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    err_d.overflow  = (bus.push & full_q) | (err_q.overflow & ~bus.err_clr);
    err_d.underflow = (bus.pop & empty_q) | (err_q.underflow & ~bus.err_clr);
  end

  sync_fifo_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.wdata),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      err_q    <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      err_q    <= err_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic [DWIDTH-1:0] head_d;

  // Look ahead at the post-edge head; a word written this edge into that slot bypasses the RAM.
  assign raddr  = rptr_d[AW-1:0];
  assign head_d = (wr_en && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) ? bus.wdata : ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (!empty_d) begin
      rdata_q <= head_d;
    end
  end

  assign bus.rvalid = ~empty_q;
`else
  logic rvalid_q;

  assign raddr = rptr_q[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  assign bus.rvalid = rvalid_q;
`endif

  assign bus.rdata     = rdata_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.afull     = afull_q;
  assign bus.aempty    = aempty_q;
  assign bus.overflow  = err_q.overflow;
  assign bus.underflow = err_q.underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (DEPTH=8, DWIDTH=8); queue-based reference model.
module tb_sync_fifo_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 8;
  localparam int unsigned AF = 6;
  localparam int unsigned AE = 2;
`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DWIDTH(DW), .DEPTH(DP)) bus ();

  sync_fifo_ctrl #(
    .DWIDTH    (DW),
    .DEPTH     (DP),
    .AFULL_TH  (AF),
    .AEMPTY_TH (AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue, plus sticky errors and the standard-mode read register.
  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_rvalid;
  logic [7:0] m_rdata;

  typedef struct {
    bit         rst, push, pop, clr;
    logic [7:0] wd;
    int         cnt;
    bit         ovf, unf, rv, chk_rd;
    logic [7:0] rd;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_update(input bit rst, push, pop, clr, input logic [7:0] wd);
    bit mf, me;
    mf = (q.size() == DP);
    me = (q.size() == 0);
    if (rst) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rvalid = 0; m_rdata = '0;
    end else begin
      m_ovf = (push && mf) || (m_ovf && !clr);
      m_unf = (pop && me) || (m_unf && !clr);
      if (pop && !me) begin
        m_rdata  = q.pop_front();
        m_rvalid = 1;
      end else begin
        m_rvalid = 0;
      end
      if (push && !mf) q.push_back(wd);
    end
  endtask

  task automatic compare_model();
    int n;
    n = q.size();
    check("mdl.count", bus.count, n);
    check("mdl.full", bus.full, n == DP);
    check("mdl.empty", bus.empty, n == 0);
    check("mdl.afull", bus.afull, n >= AF);
    check("mdl.aempty", bus.aempty, n <= AE);
    check("mdl.overflow", bus.overflow, m_ovf);
    check("mdl.underflow", bus.underflow, m_unf);
`ifdef SYNC_FIFO_FWFT_EN
    check("mdl.rvalid", bus.rvalid, n != 0);
    if (n != 0) check("mdl.rdata", bus.rdata, q[0]);
`else
    check("mdl.rvalid", bus.rvalid, m_rvalid);
    check("mdl.rdata", bus.rdata, m_rdata);
`endif
  endtask

  task automatic step(input bit rst, push, pop, clr, input logic [7:0] wd);
    reset       = rst;
    bus.push    = push;
    bus.pop     = pop;
    bus.err_clr = clr;
    bus.wdata   = wd;
    @(posedge clk);
    model_update(rst, push, pop, clr, wd);
    #1;
    compare_model();
  endtask

  function automatic void add(input bit rst, push, pop, clr, input logic [7:0] wd,
                              input int cnt, input bit ovf, unf, rv, chk_rd,
                              input logic [7:0] rd);
    vec_t v;
    v.rst = rst; v.push = push; v.pop = pop; v.clr = clr; v.wd = wd;
    v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.rv = rv; v.chk_rd = chk_rd; v.rd = rd;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1;
    bus.push = 0; bus.pop = 0; bus.err_clr = 0; bus.wdata = '0;
    m_ovf = 0; m_unf = 0; m_rvalid = 0; m_rdata = '0;

    // Fill, overflow, clear, drain, then the empty-side corner cases.
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 0, 8'(i), i, 0, 0, FWFT, 1, FWFT ? 8'h01 : 8'h00);
    add(0, 1, 0, 0, 8'h09, 8, 1, 0, FWFT, 1, FWFT ? 8'h01 : 8'h00);
    add(0, 0, 0, 1, 8'h00, 8, 0, 0, FWFT, 1, FWFT ? 8'h01 : 8'h00);
    for (int j = 1; j <= 8; j++)
      add(0, 0, 1, 0, 8'h00, 8 - j, 0, 0, FWFT ? (j < 8) : 1'b1, FWFT ? (j < 8) : 1'b1,
          FWFT ? 8'(j + 1) : 8'(j));
    add(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, !FWFT, 8'h08);
    add(0, 1, 1, 0, 8'hAA, 1, 0, 1, FWFT, 1, FWFT ? 8'hAA : 8'h08);
    add(0, 0, 1, 0, 8'h00, 0, 0, 1, !FWFT, !FWFT, 8'hAA);
    add(0, 0, 1, 1, 8'h00, 0, 0, 1, 0, !FWFT, 8'hAA);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, !FWFT, 8'hAA);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].wd);
      check($sformatf("vec%0d.count", i), bus.count, vecs[i].cnt);
      check($sformatf("vec%0d.full", i), bus.full, vecs[i].cnt == DP);
      check($sformatf("vec%0d.empty", i), bus.empty, vecs[i].cnt == 0);
      check($sformatf("vec%0d.afull", i), bus.afull, vecs[i].cnt >= AF);
      check($sformatf("vec%0d.aempty", i), bus.aempty, vecs[i].cnt <= AE);
      check($sformatf("vec%0d.overflow", i), bus.overflow, vecs[i].ovf);
      check($sformatf("vec%0d.underflow", i), bus.underflow, vecs[i].unf);
      check($sformatf("vec%0d.rvalid", i), bus.rvalid, vecs[i].rv);
      if (vecs[i].chk_rd) check($sformatf("vec%0d.rdata", i), bus.rdata, vecs[i].rd);
    end

    // Full FIFO with simultaneous push and pop: pop wins, push rejected.
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'(8'h10 + i));
    check("full.before", bus.full, 1);
    step(0, 1, 1, 0, 8'h55);
    check("fullpp.count", bus.count, 7);
    check("fullpp.overflow", bus.overflow, 1);
    check("fullpp.rdata", bus.rdata, FWFT ? 8'h11 : 8'h10);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 8'h00);
    check("fullpp.drained", bus.empty, 1);

    // Continuous push/pop at count 4 across several pointer wraps.
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'(8'h20 + i));
    for (int k = 0; k < 40; k++) begin
      step(0, 1, 1, 0, 8'(8'h30 + k));
      check($sformatf("wrap%0d.count", k), bus.count, 4);
      if (!FWFT) check($sformatf("wrap%0d.rdata", k), bus.rdata,
                       (k < 4) ? 8'(8'h20 + k) : 8'(8'h30 + k - 4));
    end

    // Reset mid-stream at count 5 overrides push/pop/err_clr.
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'(8'h40 + i));
    step(1, 1, 1, 1, 8'h77);
    check("midrst.empty", bus.empty, 1);
    check("midrst.count", bus.count, 0);
    check("midrst.rvalid", bus.rvalid, 0);
    step(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 8'(8'h60 + i));
    check("errs.overflow", bus.overflow, 1);
    check("errs.underflow", bus.underflow, 1);
    step(0, 0, 0, 1, 8'h00);
    check("errclr.overflow", bus.overflow, 0);
    check("errclr.underflow", bus.underflow, 0);

`ifdef SYNC_FIFO_FWFT_EN
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h3C);
    check("fwft.rdata", bus.rdata, 8'h3C);
    check("fwft.rvalid", bus.rvalid, 1);
`endif

    // Randomised traffic against the model.
    step(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 5, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
